imm_encode_loader: RTL

//  Inverse of the datapath immediate extender. Takes a 32-bit sign-extended immediate plus an

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/imm_scatter.sv | 45 ++++
 rtl/imm_encode_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: immediate format codes
// and the program-loader state encoding.
package rv32i_pkg;

   localparam logic [1:0] IMM_I    = 2'b00;
   localparam logic [1:0] IMM_S    = 2'b01;
   localparam logic [1:0] IMM_B    = 2'b10;
   localparam logic [1:0] IMM_NONE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_DONE = 2'b10
   } ld_state_t;

endpackage

// File: rtl/imm_scatter.sv
// Scatters a sign-extended immediate into the I/S/B
// fields of a base instruction and flags range errors.
module imm_scatter
   import rv32i_pkg::*;
(
   input  logic [1:0]  ImmSrc,
   input  logic [31:0] Imm,
   input  logic [31:0] Base,
   output logic [31:0] Word,
   output logic        Legal
);

   logic fit12;
   logic fit13;

   // Upper bits must be pure sign extension of the field.
   assign fit12 = (&Imm[31:11]) | ~(|Imm[31:11]);
   assign fit13 = (&Imm[31:12]) | ~(|Imm[31:12]);

   always_comb begin
      Word  = Base;
      Legal = 1'b1;
      unique case (ImmSrc)
         IMM_I: begin
            Word  = {Imm[11:0], Base[19:0]};
            Legal = fit12;
         end
         IMM_S: begin
            Word  = {Imm[11:5], Base[24:12],
                     Imm[4:0], Base[6:0]};
            Legal = fit12;
         end
         IMM_B: begin
            Word  = {Imm[12], Imm[10:5], Base[24:12],
                     Imm[4:1], Imm[11], Base[6:0]};
            Legal = fit13 & ~Imm[0];
         end
         IMM_NONE: begin
            Word  = Base;
            Legal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encode_loader.sv
// Program loader: encodes immediates into instruction
// words and writes them to consecutive memory words.
module imm_encode_loader
   import rv32i_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   localparam int         CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          Start,
   input  logic          In_Valid,
   output logic          In_Ready,
   input  logic [1:0]    ImmSrc,
   input  logic [31:0]   Imm,
   input  logic [31:0]   Base,
   output logic          WE,
   output logic [31:0]   A,
   output logic [31:0]   WD,
   output logic [CW-1:0] Count,
   output logic          Done,
   output logic          Err
);

   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   ld_state_t   state;
   ld_state_t   state_d;
   logic [31:0] word;
   logic        legal;
   logic        acc;
   logic        full_hit;
   logic [31:0] nxt;

   imm_scatter u_scatter (
      .ImmSrc (ImmSrc),
      .Imm    (Imm),
      .Base   (Base),
      .Word   (word),
      .Legal  (legal)
   );

   assign In_Ready = (state == ST_LOAD) & ~Start;
   assign acc      = In_Valid & In_Ready;
   assign full_hit = acc & legal & (Count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE: if (Start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (Start)         state_d = ST_LOAD;
            else if (full_hit) state_d = ST_DONE;
         end
         ST_DONE: if (Start) state_d = ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   // nxt is the address of the next write; A holds the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WE    <= 1'b0;
         A     <= BASE_ADDR;
         WD    <= '0;
         Count <= '0;
         Done  <= 1'b0;
         Err   <= 1'b0;
         nxt   <= BASE_ADDR;
      end else begin
         WE <= acc & legal;
         if (Start) begin
            Count <= '0;
            Done  <= 1'b0;
            Err   <= 1'b0;
            nxt   <= BASE_ADDR;
            A     <= BASE_ADDR;
         end else if (acc) begin
            if (legal) begin
               A     <= nxt;
               WD    <= word;
               nxt   <= nxt + 32'd4;
               Count <= Count + 1'b1;
               if (Count == LAST) Done <= 1'b1;
            end else begin
               Err <= 1'b1;
            end
         end
      end
   end

endmodule
